i2c_byte_master: RTL
====================

# i2c_byte_master

Single-byte I2C master that drives the open-drain `sda_out`/`scl_out` lines consumed by the chip's bidirectional pads and samples `sda_in`/`scl_in` returned from them. It executes one complete transaction per command (START, 7-bit address + R/W, one data byte, STOP) for the sensor-polling logic inside `main`. The line convention matches the pad ring: output 1 means released (pad driver off, pulled up), output 0 means driven low.

## Interface
- `CLK_DIV`, default 64: system clocks per SCL quarter-period. Legal range is ≥ 4.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: command strobe. Accepted only while `busy`=0.
- `dev_addr` input 7: target address. Latched on accept.
- `rw` input 1: 1 = read, 0 = write. Latched on accept.
- `wdata` input 8: write byte. Latched on accept.
- `sda_in` input 1: SDA level from the pad. Asynchronous.
- `scl_in` input 1: SCL level from the pad. Asynchronous.
- `sda_out` output 1: SDA drive. 0 pulls the line low; 1 releases it.
- `scl_out` output 1: SCL drive. 0 pulls the line low; 1 releases it.
- `busy` output 1: high from the cycle after accept until `done`.
- `done` output 1: one-cycle pulse at the end of the transaction.
- `rdata` output 8: received byte. Valid from `done` until the next accepted read.
- `ack_error` output 1: the slave NACKed the address or the write data. Valid with `done` and held until the next accept.

## Operation
**Synchronizer**
- `sda_in` and `scl_in` each pass through a 2-flop synchronizer. All internal decisions use the synchronized values.

**Bit timing**
- Every bit slot consists of 4 quarters, q0–q3.
- q0: SCL low, SDA updated. q1: SCL low. q2: SCL released. q3: SCL released.
- Slave input is sampled on the last cycle of q2.
- Each quarter lasts `CLK_DIV` cycles, except for clock stretching (below).

**Clock stretching**
- The q2 counter does not advance until synchronized `scl_in`=1.
- There is no timeout.

**States**
- IDLE → START → ADDR → AACK → DATA → DACK → STOP → IDLE.
- IDLE: both lines released. `start` with `busy`=0 latches the inputs and enters START. `start` is ignored while `busy`=1.
- START: q0 and q1 release both lines; q2 and q3 hold SDA low with SCL released.
- ADDR: 8 bits, MSB first: `dev_addr[6:0]`, then `rw`.
- AACK: SDA released; sample it in q2. If it reads 1: set `ack_error` and go to STOP, skipping DATA and DACK.
- DATA, write: shift `wdata` out MSB first.
- DATA, read: SDA released; shift the sampled bits into a shift register MSB first.
- DACK, write: sample SDA; a 1 sets `ack_error`.
- DACK, read: master drives SDA=1 (NACK, single-byte read). `rdata` is updated from the shift register at the end of this slot.
- STOP: q0 SCL low, SDA low; q1 SCL released, SDA low; q2 SDA low, SCL high; q3 SDA released.
- After STOP: `done`=1 for one cycle, `busy`=0 in that same cycle, then return to IDLE.
- A new `start` is accepted in the cycle after `done`.

**Reset**
- `rst` may assert mid-transaction. It immediately releases both lines and returns to IDLE without generating a STOP.
- Reset values: `sda_out`=1, `scl_out`=1, `busy`=0, `done`=0, `ack_error`=0, `rdata`=0, synchronizer flops = 1.

## Timing
- Accept to `busy`=1: 1 cycle.
- With no stretching, a complete transaction is (1 START + 9 ADDR/AACK + 9 DATA/DACK + 1 STOP) × 4 × `CLK_DIV` cycles. For `CLK_DIV`=64 this is 5120 cycles from the first START cycle to the `done` cycle.
- An address NACK skips 9 slots, giving 11 × 4 × `CLK_DIV` cycles.
- A stretched q2 adds the number of cycles synchronized `scl_in` stays low after release. This includes the 2-cycle synchronizer lag.
- SDA changes only in q0, or inside START/STOP as defined above. SDA never changes while SCL is released during a data or ACK slot.
- `start` asserted in the same cycle as `done`: ignored.

## Test plan
- **Write, slave ACKs all:** `CLK_DIV`=4, `dev_addr`=0x48, `rw`=0, `wdata`=0xA5; bench slave ACKs every byte → bench decodes address byte 0x90 and data byte 0xA5; `done` pulses exactly 320 cycles after START begins; `ack_error`=0.
- **Read with master NACK:** `dev_addr`=0x48, `rw`=1; slave returns 0x3C → address byte 0x91 on the bus; master SDA=1 in DACK; `rdata`=0x3C at `done`; `ack_error`=0.
- **Address NACK:** slave leaves SDA high in AACK → no data slot, STOP follows immediately; `ack_error`=1; `done` at 11×16 = 176 cycles.
- **Clock stretching:** slave holds `scl_in` low for 50 cycles in the q2 of ADDR bit 3 → transaction lengthens by 50–52 cycles; no bit is corrupted; `rdata`/`ack_error` unchanged versus the unstretched run.
- **Start while busy:** pulse `start` mid-ADDR with `dev_addr`=0x11 → ignored; the bus still carries the original address; exactly one `done` pulse.
- **Reset mid-DATA:** assert `rst` during DATA bit 4 → `sda_out`=`scl_out`=1, `busy`=0 immediately (asynchronously); a fresh write after deassert completes normally.

Source files
------------

// File: rtl/i2c_byte_master_if.sv
// Command, status and pad-side signals of the single-byte I2C master.
// The master modport is the controller's view; slave is the user/pad-ring side.
interface i2c_byte_master_if;
  logic       start;
  logic [6:0] dev_addr;
  logic       rw;
  logic [7:0] wdata;
  logic       sda_in;
  logic       scl_in;
  logic       sda_out;
  logic       scl_out;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       ack_error;

  modport master (
    input  start, dev_addr, rw, wdata, sda_in, scl_in,
    output sda_out, scl_out, busy, done, rdata, ack_error
  );

  modport slave (
    output start, dev_addr, rw, wdata, sda_in, scl_in,
    input  sda_out, scl_out, busy, done, rdata, ack_error
  );
endinterface

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP per command.
// Bit slots are four CLK_DIV-cycle quarters; q2 honours slave clock stretching.
module i2c_byte_master #(
  parameter int unsigned CLK_DIV = 64
) (
  input logic                  clk,
  input logic                  rst,
  i2c_byte_master_if.master    io_bus
);

  localparam int unsigned    CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CntLast = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StAack, StData, StDack, StStop, StDone
  } state_e;

  state_e        r_state, w_state_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic [1:0]    r_q, w_q_d;
  logic [2:0]    r_bit, w_bit_d;
  logic [7:0]    r_shift, w_shift_d;
  logic [7:0]    r_wdata, w_wdata_d;
  logic          r_rw, w_rw_d;
  logic          r_ack_error, w_ack_error_d;
  logic [7:0]    r_rdata, w_rdata_d;
  logic          r_sda_meta, r_sda_sync, r_scl_meta, r_scl_sync;
  logic          r_sda_out, w_sda_d, r_scl_out, w_scl_d;
  logic          w_adv, w_qend, w_sample, w_slot_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_q         <= 2'd0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_wdata     <= 8'h00;
      r_rw        <= 1'b0;
      r_ack_error <= 1'b0;
      r_rdata     <= 8'h00;
      r_sda_meta  <= 1'b1;
      r_sda_sync  <= 1'b1;
      r_scl_meta  <= 1'b1;
      r_scl_sync  <= 1'b1;
      r_sda_out   <= 1'b1;
      r_scl_out   <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_q         <= w_q_d;
      r_bit       <= w_bit_d;
      r_shift     <= w_shift_d;
      r_wdata     <= w_wdata_d;
      r_rw        <= w_rw_d;
      r_ack_error <= w_ack_error_d;
      r_rdata     <= w_rdata_d;
      r_sda_meta  <= io_bus.sda_in;
      r_sda_sync  <= r_sda_meta;
      r_scl_meta  <= io_bus.scl_in;
      r_scl_sync  <= r_scl_meta;
      r_sda_out   <= w_sda_d;
      r_scl_out   <= w_scl_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_q_d         = r_q;
    w_bit_d       = r_bit;
    w_shift_d     = r_shift;
    w_wdata_d     = r_wdata;
    w_rw_d        = r_rw;
    w_ack_error_d = r_ack_error;
    w_rdata_d     = r_rdata;

    // The first two q2 cycles cover the synchronizer lag after SCL release;
    // from then on q2 stalls while the slave holds SCL low.
    w_adv      = !((r_q == 2'd2) && (r_cnt >= CW'(2)) && !r_scl_sync);
    w_qend     = w_adv && (r_cnt == CntLast);
    w_sample   = w_qend && (r_q == 2'd2);
    w_slot_end = w_qend && (r_q == 2'd3);

    if ((r_state != StIdle) && (r_state != StDone) && w_adv) begin
      w_cnt_d = w_qend ? '0 : r_cnt + CW'(1);
      if (w_qend) w_q_d = r_q + 2'd1;
    end

    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_shift_d     = {io_bus.dev_addr, io_bus.rw};
          w_wdata_d     = io_bus.wdata;
          w_rw_d        = io_bus.rw;
          w_ack_error_d = 1'b0;
          w_cnt_d       = '0;
          w_q_d         = 2'd0;
          w_state_d     = StStart;
        end
      end
      StStart: begin
        if (w_slot_end) begin
          w_bit_d   = 3'd7;
          w_state_d = StAddr;
        end
      end
      StAddr: begin
        if (w_slot_end) begin
          w_shift_d = {r_shift[6:0], 1'b1};
          if (r_bit == 3'd0) w_state_d = StAack;
          else               w_bit_d   = r_bit - 3'd1;
        end
      end
      StAack: begin
        if (w_sample && r_sda_sync) w_ack_error_d = 1'b1;
        if (w_slot_end) begin
          w_shift_d = r_wdata;
          w_bit_d   = 3'd7;
          w_state_d = r_ack_error ? StStop : StData;
        end
      end
      StData: begin
        if (w_sample && r_rw) w_shift_d = {r_shift[6:0], r_sda_sync};
        if (w_slot_end) begin
          if (!r_rw) w_shift_d = {r_shift[6:0], 1'b1};
          if (r_bit == 3'd0) w_state_d = StDack;
          else               w_bit_d   = r_bit - 3'd1;
        end
      end
      StDack: begin
        if (w_sample && !r_rw && r_sda_sync) w_ack_error_d = 1'b1;
        if (w_slot_end) begin
          if (r_rw) w_rdata_d = r_shift;
          w_state_d = StStop;
        end
      end
      StStop: begin
        if (w_slot_end) w_state_d = StDone;
      end
      StDone: begin
        w_state_d = StIdle;
      end
    endcase

    // Line drive is decoded from next state so the pads come straight off flops.
    w_scl_d = 1'b1;
    w_sda_d = 1'b1;
    unique case (w_state_d)
      StStart: w_sda_d = !w_q_d[1];
      StAddr: begin
        w_scl_d = w_q_d[1];
        w_sda_d = w_shift_d[7];
      end
      StAack, StDack: w_scl_d = w_q_d[1];
      StData: begin
        w_scl_d = w_q_d[1];
        w_sda_d = w_rw_d | w_shift_d[7];
      end
      StStop: begin
        w_scl_d = (w_q_d != 2'd0);
        w_sda_d = (w_q_d == 2'd3);
      end
      StIdle, StDone: ;
    endcase
  end

  assign io_bus.sda_out   = r_sda_out;
  assign io_bus.scl_out   = r_scl_out;
  assign io_bus.busy      = (r_state != StIdle) && (r_state != StDone);
  assign io_bus.done      = (r_state == StDone);
  assign io_bus.rdata     = r_rdata;
  assign io_bus.ack_error = r_ack_error;

endmodule
